// File: rtl/lock_pkg.sv
// Shared types and constants for the lock supervisor: state encoding,
// default timing parameters and the width of the remaining-time counter.
package lock_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_OPEN    = 3'd1,
        S_LOCKOUT = 3'd2,
        S_ALARM   = 3'd3,
        S_PULSE   = 3'd4
    } state_t;

    localparam int DEF_RELOCK_SEC   = 10;
    localparam int DEF_LOCKOUT_SEC  = 30;
    localparam int DEF_MAX_LOCKOUTS = 3;
    localparam int DEF_RST_CYCLES   = 2;

    localparam int REM_W = 8;

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector; a held level yields a single-cycle flag.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_r;

    always_ff @(posedge clk) begin
        if (reset) din_r <= 1'b0;
        else       din_r <= din;
    end

    assign rise = din & ~din_r;

endmodule

// File: rtl/lock_supervisor.sv
// Supervisor above the combination-lock unit: schedules auto/manual relock,
// timed lockouts escalating to a latched alarm, and admin override.
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int RELOCK_SEC   = DEF_RELOCK_SEC,
    parameter int LOCKOUT_SEC  = DEF_LOCKOUT_SEC,
    parameter int MAX_LOCKOUTS = DEF_MAX_LOCKOUTS,
    parameter int RST_CYCLES   = DEF_RST_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             lock,
    input  logic             unlock,
    input  logic             relock,
    input  logic             admin,
    output logic             unit_reset,
    output logic             door_open,
    output logic             alarm,
    output logic [REM_W-1:0] remaining,
    output logic [2:0]       lockout_cnt
);

    localparam logic [REM_W-1:0] RELOCK_L  = REM_W'(RELOCK_SEC);
    localparam logic [REM_W-1:0] LOCKOUT_L = REM_W'(LOCKOUT_SEC);
    localparam logic [2:0]       MAX_L     = 3'(MAX_LOCKOUTS);
    localparam logic [3:0]       PULSE_END = 4'(RST_CYCLES - 1);

    state_t           state, state_n;
    logic [REM_W-1:0] rem_n, rem_dec;
    logic [2:0]       cnt_n, cnt_inc;
    logic [3:0]       pulse_cnt, pulse_n;
    logic             relock_flag, admin_flag;

    edge_detect u_relock_ed (.clk(clk), .reset(reset), .din(relock), .rise(relock_flag));
    edge_detect u_admin_ed  (.clk(clk), .reset(reset), .din(admin),  .rise(admin_flag));

    assign rem_dec = (remaining == '0) ? '0 : remaining - 1'b1;
    assign cnt_inc = (lockout_cnt >= MAX_L) ? MAX_L : lockout_cnt + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            remaining   <= '0;
            lockout_cnt <= '0;
            pulse_cnt   <= '0;
        end else begin
            state       <= state_n;
            remaining   <= rem_n;
            lockout_cnt <= cnt_n;
            pulse_cnt   <= pulse_n;
        end
    end

    // Pulse counter defaults to 0 so every entry into S_PULSE starts a fresh count.
    always_comb begin
        state_n = state;
        rem_n   = remaining;
        cnt_n   = lockout_cnt;
        pulse_n = '0;
        if (admin_flag && state != S_PULSE) begin
            state_n = S_PULSE;
            rem_n   = '0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (unlock) begin
                        state_n = S_OPEN;
                        rem_n   = RELOCK_L;
                        cnt_n   = '0;
                    end else if (lock) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == MAX_L) begin
                            state_n = S_ALARM;
                        end else begin
                            state_n = S_LOCKOUT;
                            rem_n   = LOCKOUT_L;
                        end
                    end
                end
                S_OPEN: begin
                    if (relock_flag) begin
                        state_n = S_PULSE;
                        rem_n   = '0;
                    end else if (tick) begin
                        rem_n = rem_dec;
                        if (remaining <= 1) state_n = S_PULSE;
                    end
                end
                S_LOCKOUT: begin
                    if (tick) begin
                        rem_n = rem_dec;
                        if (remaining <= 1) state_n = S_PULSE;
                    end
                end
                S_ALARM: ;
                S_PULSE: begin
                    rem_n = '0;
                    if (pulse_cnt >= PULSE_END) state_n = S_IDLE;
                    else                        pulse_n = pulse_cnt + 4'd1;
                end
                default: begin
                    state_n = S_IDLE;
                    rem_n   = '0;
                end
            endcase
        end
    end

    assign unit_reset = (state == S_PULSE);
    assign door_open  = (state == S_OPEN);
    assign alarm      = (state == S_ALARM);

endmodule
